// File: rtl/fsic_io_serdes_tx_if.sv
// Parallel word handshake into the serializer: the source drives word/valid,
// and the serializer answers with ready.
interface fsic_io_serdes_tx_if #(
  parameter int pCLK_RATIO = 4
);
  logic [pCLK_RATIO-1:0] txdata_in;
  logic                  txdata_in_valid;
  logic                  txdata_in_ready;

  modport master (
    output txdata_in,
    output txdata_in_valid,
    input  txdata_in_ready
  );

  modport slave (
    input  txdata_in,
    input  txdata_in_valid,
    output txdata_in_ready
  );
endinterface

// File: rtl/fsic_io_serdes_tx.sv
// LSB-first serializer fed by a two-word buffer. Words go out back-to-back
// while txen holds, and an all-zero idle word fills in when the buffer runs dry.
module fsic_io_serdes_tx #(
  parameter int pCLK_RATIO    = 4,
  parameter int pTX_BUF_DEPTH = 2
) (
  input  logic                      ioclk,
  input  logic                      axis_rst_n,
  input  logic                      txen,
  fsic_io_serdes_tx_if.slave        tx,
  output logic                      Serial_Data_out,
  output logic                      tx_word_start,
  output logic                      tx_underrun
);

  localparam int PHASE_W = (pCLK_RATIO > 1) ? $clog2(pCLK_RATIO) : 1;
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(pCLK_RATIO - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  state_t                next_state;
  logic [pCLK_RATIO-1:0] buf_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [PHASE_W-1:0]    phase;
  logic [pCLK_RATIO-1:0] shift_reg;
  logic                  push;
  logic                  pop;
  logic                  load_idle;
  logic                  shift_en;

  assign tx.txdata_in_ready = (count < 2'(pTX_BUF_DEPTH));
  assign push               = tx.txdata_in_valid && tx.txdata_in_ready;

  assign Serial_Data_out = (state == RUN) ? shift_reg[0] : 1'b0;
  assign tx_word_start   = (state == RUN) && (phase == '0);

  // A word may only leave txen-low at its last bit, so a word in flight always completes.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load_idle  = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (txen && (count != 2'd0)) begin
          pop        = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (phase != LAST_PHASE) begin
          shift_en = 1'b1;
        end else if (!txen) begin
          next_state = IDLE;
        end else if (count != 2'd0) begin
          pop = 1'b1;
        end else begin
          load_idle = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state       <= IDLE;
      buf_mem[0]  <= '0;
      buf_mem[1]  <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      phase       <= '0;
      shift_reg   <= '0;
      tx_underrun <= 1'b0;
    end else begin
      state <= next_state;

      if (push) begin
        buf_mem[wr_ptr] <= tx.txdata_in;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      // Pop decisions use the pre-edge count, so a word pushed into an empty buffer waits one edge.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (pop) begin
        shift_reg <= buf_mem[rd_ptr];
        phase     <= '0;
      end else if (load_idle) begin
        shift_reg   <= '0;
        phase       <= '0;
        tx_underrun <= 1'b1;
      end else if (shift_en) begin
        shift_reg <= shift_reg >> 1;
        phase     <= phase + PHASE_W'(1);
      end else if (next_state == IDLE) begin
        phase <= '0;
      end
    end
  end

endmodule

// File: doc/fsic_io_serdes_tx.md
FSIC_IO_SERDES_TX -- requirements
Module: fsic_io_serdes_tx

Interface
REQ-001 SHALL have parameter pCLK_RATIO, default 4: serialization ratio, i.e. bits per parallel word.
REQ-002 SHALL have parameter pTX_BUF_DEPTH, default 2: depth of the parallel word buffer; only the value 2 is supported.
REQ-003 SHALL have port ioclk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port axis_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port txen, input, 1 bit: transmit enable.
REQ-006 SHALL have port txdata_in, input, pCLK_RATIO bits: parallel word to send.
REQ-007 SHALL have port txdata_in_valid, input, 1 bit: txdata_in is valid.
REQ-008 SHALL have port txdata_in_ready, output, 1 bit: the buffer can accept a word.
REQ-009 SHALL have port Serial_Data_out, output, 1 bit: serial stream, LSB first.
REQ-010 SHALL have port tx_word_start, output, 1 bit: high during the cycle the LSB of a word is on Serial_Data_out.
REQ-011 SHALL have port tx_underrun, output, 1 bit: sticky flag, set when an idle word is inserted.

Function
REQ-012 SHALL accept a word (push) on a posedge where txdata_in_valid=1 and txdata_in_ready=1; txdata_in_ready SHALL be combinational (buffer count < 2).
REQ-013 SHALL ignore txdata_in_valid while the buffer is full; the word is neither stored nor overwritten.
REQ-014 SHALL implement the buffer as a 2-entry FIFO with 1-bit wrapping read/write pointers and a count of 0..2; a push and pop in the same cycle leaves the count unchanged, and with count=1 the pushed word becomes the new head.
REQ-015 SHALL have the FSM states IDLE and RUN, with a phase counter of $clog2(pCLK_RATIO) bits and a shift register of pCLK_RATIO bits.
REQ-016 In IDLE, when txen=1 and count!=0: on the next edge SHALL load the head into the shift register, pop the head, set phase=0 and enter RUN.
REQ-017 In IDLE, when txen=0 or count=0: SHALL remain in IDLE.
REQ-018 In RUN, Serial_Data_out SHALL equal shift_reg[0]; in IDLE it SHALL be 0.
REQ-019 In RUN with phase<pCLK_RATIO-1: each edge SHALL shift the register right by 1 (zero fill) and increment phase.
REQ-020 In RUN at phase=pCLK_RATIO-1 (word boundary), when txen=0: SHALL enter IDLE, so the current word always completes.
REQ-021 At the word boundary with txen=1 and count!=0: SHALL load the head, pop, set phase=0 and stay in RUN, giving back-to-back words with no gap bit.
REQ-022 At the word boundary with txen=1 and count=0: SHALL load an all-zero idle word, set phase=0, set tx_underrun=1 and stay in RUN.
REQ-023 A push and a load/pop in the same cycle SHALL both take effect, so a word pushed into an empty buffer cannot be popped in that same cycle.
REQ-024 tx_word_start SHALL equal (state==RUN && phase==0).
REQ-025 Latency: a word pushed at edge E0 into an empty buffer with txen=1 in IDLE SHALL have bit0 on Serial_Data_out in the cycle after E1, and bit k in the cycle after E(1+k).
REQ-026 The bit order SHALL match fsic_io_serdes_rx: the first serial bit lands in rxdata_out[0].
REQ-027 tx_underrun SHALL be cleared only by reset.

Reset
REQ-028 While axis_rst_n=0, asynchronously: state=IDLE, count=0, pointers=0, phase=0, shift register=0, tx_underrun=0.
REQ-029 While axis_rst_n=0: Serial_Data_out=0, tx_word_start=0 and txdata_in_ready=1.
REQ-030 Reset asserted mid-word SHALL abort the word immediately; buffered words SHALL be discarded.
REQ-031 After reset release, the first transmitted bit SHALL come from the first word pushed after release.

Verification
REQ-032 Single word: pCLK_RATIO=4, txen=1, push 4'b1011 -> Serial_Data_out = 1,1,0,1 on 4 consecutive cycles, tx_word_start high on the first; then idle word 0,0,0,0 and tx_underrun=1.
REQ-033 Streaming: push 4'hA, 4'h5, 4'hC back-to-back, honouring ready -> 12 contiguous bits 0101_1010_0011; ready drops while count=2; tx_underrun stays 0 until the stream ends.
REQ-034 Full buffer: with txen=0, push 3 words -> ready=0 after 2 pushes; the third word is dropped; after setting txen=1 only the first two words appear.
REQ-035 txen drop: deassert txen during phase 1 -> remaining bits of the current word are sent, then IDLE with Serial_Data_out=0; the buffered word is retained and sent after txen=1.
REQ-036 Reset mid-word: assert axis_rst_n=0 at phase 2 -> Serial_Data_out=0 and ready=1 immediately; after release, a new push 4'h9 transmits 1,0,0,1.
REQ-037 Loopback: connect to fsic_io_serdes_rx with a common clock, push a 16-word ramp -> rxdata_out reproduces the ramp in order.
